// File: rtl/cache_flush_sequencer.sv
// Orders a whole-hierarchy flush: both L1 caches must finish before the L2 is
// told to flush; in_flush_mode spans the sequence from request to L2 completion.
module cache_flush_sequencer #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush_req_l1i,
   input  logic             flush_req_l1d,
   input  logic             l1i_flush_complete,
   input  logic             l1d_flush_complete,
   input  logic             l2_flush_complete,
   output logic             in_flush_mode,
   output logic             flush_l2_req,
   output logic             flush_done,
   output logic [2:0]       flush_state,
   output logic [CNT_W-1:0] flush_count
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WAIT_BOTH = 3'd1,
      GOT_L1D   = 3'd2,
      GOT_L1I   = 3'd3,
      FLUSH_L2  = 3'd4
   } state_e;

   state_e           state_q, state_d;
   logic             mode_q, mode_d;
   logic             l2_req_q, l2_req_d;
   logic             done_q, done_d;
   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      l2_req_d = 1'b0;
      done_d   = 1'b0;
      count_d  = count_q;
      case (state_q)
         IDLE: begin
            // A side that was not requested counts as already finished.
            if (flush_req_l1i && flush_req_l1d) begin
               state_d = WAIT_BOTH;
               mode_d  = 1'b1;
            end else if (flush_req_l1i) begin
               state_d = GOT_L1D;
               mode_d  = 1'b1;
            end else if (flush_req_l1d) begin
               state_d = GOT_L1I;
               mode_d  = 1'b1;
            end
         end
         WAIT_BOTH: begin
            if (l1i_flush_complete && l1d_flush_complete) begin
               state_d  = FLUSH_L2;
               l2_req_d = 1'b1;
            end else if (l1d_flush_complete) begin
               state_d = GOT_L1D;
            end else if (l1i_flush_complete) begin
               state_d = GOT_L1I;
            end
         end
         GOT_L1D: begin
            if (l1i_flush_complete) begin
               state_d  = FLUSH_L2;
               l2_req_d = 1'b1;
            end
         end
         GOT_L1I: begin
            if (l1d_flush_complete) begin
               state_d  = FLUSH_L2;
               l2_req_d = 1'b1;
            end
         end
         FLUSH_L2: begin
            // Completion is honoured even in the cycle the request pulse is out.
            if (l2_flush_complete) begin
               state_d = IDLE;
               mode_d  = 1'b0;
               done_d  = 1'b1;
               count_d = count_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            mode_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         mode_q   <= 1'b0;
         l2_req_q <= 1'b0;
         done_q   <= 1'b0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         mode_q   <= mode_d;
         l2_req_q <= l2_req_d;
         done_q   <= done_d;
         count_q  <= count_d;
      end
   end

   assign in_flush_mode = mode_q;
   assign flush_l2_req  = l2_req_q;
   assign flush_done    = done_q;
   assign flush_state   = state_q;
   assign flush_count   = count_q;

endmodule

// File: tb/tb_cache_flush_sequencer.sv
// Randomized and directed stimulus for cache_flush_sequencer, checked by a
// scoreboard fed from a side-tracking reference model.
module tb_cache_flush_sequencer;

   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          flush_req_l1i = 1'b0;
   logic          flush_req_l1d = 1'b0;
   logic          l1i_flush_complete = 1'b0;
   logic          l1d_flush_complete = 1'b0;
   logic          l2_flush_complete = 1'b0;
   logic          in_flush_mode;
   logic          flush_l2_req;
   logic          flush_done;
   logic [2:0]    flush_state;
   logic [CW-1:0] flush_count;

   cache_flush_sequencer #(.CNT_W(CW)) dut (
      .clk                (clk),
      .reset              (reset),
      .flush_req_l1i      (flush_req_l1i),
      .flush_req_l1d      (flush_req_l1d),
      .l1i_flush_complete (l1i_flush_complete),
      .l1d_flush_complete (l1d_flush_complete),
      .l2_flush_complete  (l2_flush_complete),
      .in_flush_mode      (in_flush_mode),
      .flush_l2_req       (flush_l2_req),
      .flush_done         (flush_done),
      .flush_state        (flush_state),
      .flush_count        (flush_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      int st;
      int mode;
      int l2req;
      int done;
      int cnt;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;

   // Reference model: which L1 sides are still outstanding, whether the L2 phase
   // has begun, and how many sequences have completed.
   bit m_active = 0, m_needi = 0, m_needd = 0, m_l2 = 0;
   int m_count = 0;

   task automatic chk(input string nm, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
      end
   endtask

   task automatic model_step(input bit ri, input bit rd, input bit ci, input bit cd, input bit c2);
      exp_t e;
      bit   l2p = 0;
      bit   dn = 0;
      if (!m_active) begin
         if (ri || rd) begin
            m_active = 1;
            m_needi  = ri;
            m_needd  = rd;
            m_l2     = 0;
         end
      end else if (m_l2) begin
         if (c2) begin
            m_active = 0;
            m_l2     = 0;
            dn       = 1;
            m_count  = (m_count + 1) % (1 << CW);
         end
      end else begin
         if (ci) m_needi = 0;
         if (cd) m_needd = 0;
         if (!m_needi && !m_needd) begin
            m_l2 = 1;
            l2p  = 1;
         end
      end
      if (!m_active)               e.st = 0;
      else if (m_l2)               e.st = 4;
      else if (m_needi && m_needd) e.st = 1;
      else if (m_needi)            e.st = 2;
      else                         e.st = 3;
      e.mode  = m_active;
      e.l2req = l2p;
      e.done  = dn;
      e.cnt   = m_count;
      sb.push_back(e);
   endtask

   task automatic cyc(input bit ri, input bit rd, input bit ci, input bit cd, input bit c2);
      @(negedge clk);
      flush_req_l1i      = ri;
      flush_req_l1d      = rd;
      l1i_flush_complete = ci;
      l1d_flush_complete = cd;
      l2_flush_complete  = c2;
      model_step(ri, rd, ci, cd, c2);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_state"}, int'(flush_state), 0);
      chk({tag, "_mode"}, int'(in_flush_mode), 0);
      chk({tag, "_l2req"}, int'(flush_l2_req), 0);
      chk({tag, "_done"}, int'(flush_done), 0);
      chk({tag, "_count"}, int'(flush_count), 0);
   endtask

   // Monitor: every pushed expectation belongs to the next rising edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("state", int'(flush_state), e.st);
            chk("in_flush_mode", int'(in_flush_mode), e.mode);
            chk("flush_l2_req", int'(flush_l2_req), e.l2req);
            chk("flush_done", int'(flush_done), e.done);
            chk("flush_count", int'(flush_count), e.cnt);
         end
      end
   end

   initial begin
      #1;
      chk_reset_vals("reset_init");
      @(negedge clk);
      reset = 1'b1;

      // Completion inputs while idle must do nothing.
      cyc(0, 0, 1, 0, 0);
      cyc(0, 0, 0, 1, 1);
      cyc(0, 0, 1, 1, 1);
      idle(2);

      // Both requests, L1D then L1I, then L2 some cycles later.
      cyc(1, 1, 0, 0, 0);
      idle(2);
      cyc(0, 0, 0, 1, 0);
      idle(1);
      cyc(0, 0, 1, 0, 0);
      idle(3);
      cyc(0, 0, 0, 0, 1);
      idle(2);

      // L1D-only request: an early L1I pulse is ignored.
      cyc(0, 1, 0, 0, 0);
      idle(1);
      cyc(0, 0, 1, 0, 0);
      idle(1);
      cyc(0, 0, 0, 1, 0);
      idle(1);
      cyc(0, 0, 0, 0, 1);
      idle(1);

      // L1I-only request with stray completions on the finished side.
      cyc(1, 0, 0, 1, 1);
      cyc(0, 0, 0, 1, 1);
      cyc(0, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 1);
      idle(1);

      // Simultaneous L1 completions, L2 completion in the first FLUSH_L2 cycle.
      cyc(1, 1, 0, 0, 0);
      cyc(0, 0, 1, 1, 0);
      cyc(1, 1, 0, 0, 1);
      cyc(0, 0, 0, 0, 1);
      idle(2);

      // Reset asserted while in GOT_L1I.
      cyc(0, 1, 0, 0, 0);
      idle(1);
      @(negedge clk);
      flush_req_l1i = 0; flush_req_l1d = 0;
      l1i_flush_complete = 0; l1d_flush_complete = 0; l2_flush_complete = 0;
      #1 reset = 1'b0;
      #1;
      chk_reset_vals("reset_mid");
      m_active = 0; m_needi = 0; m_needd = 0; m_l2 = 0; m_count = 0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      idle(2);
      cyc(1, 1, 0, 0, 0);
      cyc(0, 0, 1, 0, 0);
      cyc(0, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 1);
      idle(1);

      // Counter wrap: 2^CW + 1 minimum-length sequences.
      for (int s = 0; s < (1 << CW) + 1; s++) begin
         cyc(1, 1, 0, 0, 0);
         cyc(0, 0, 1, 1, 0);
         cyc(0, 0, 0, 0, 1);
      end
      idle(1);

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 3) == 0));
      end
      idle(2);

      @(posedge clk);
      #2;
      chk("scoreboard_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
